// File: rtl/rr_mux_pkg.sv
// Shared types for the round-robin byte mux front end.
package rr_mux_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/rr_mux_arb_mux.sv
// Combinational 2:1 byte mux: y_o follows b_i when SRC_B is selected, else a_i.
// No latency, no flow control.
module rr_mux_arb_mux
    import rr_mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  src_e              sel_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = (sel_i == SRC_B) ? b_i : a_i;

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin arbiter between two byte sources feeding a one-entry output register; 1-cycle latency.
// Sources stall (ready low) while the register is full and not draining; drain and reload share one edge.
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_src_o,
    input  logic              out_ready_i
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    src_e              out_src_q,   out_src_d;
    src_e              last_grant_q, last_grant_d;

    logic              can_load;
    logic              grant_a;
    logic              grant_b;
    src_e              sel;
    logic [DATA_W-1:0] mux_y;

    assign can_load = !out_valid_q || out_ready_i;

    // Nothing is accepted while reset is asserted, so readies stay low then too.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset_n && can_load) begin
            if (a_valid_i && !b_valid_i) begin
                grant_a = 1'b1;
            end else if (!a_valid_i && b_valid_i) begin
                grant_b = 1'b1;
            end else if (a_valid_i && b_valid_i) begin
                if (last_grant_q == SRC_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end
        end
    end

    assign sel       = grant_b ? SRC_B : SRC_A;
    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;

    rr_mux_arb_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .a_i   (a_data_i),
        .b_i   (b_data_i),
        .sel_i (sel),
        .y_o   (mux_y)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (grant_a || grant_b) begin
            out_valid_d  = 1'b1;
            out_data_d   = mux_y;
            out_src_d    = sel;
            last_grant_d = sel;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // last_grant resets to B so that A wins the first contention.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= SRC_A;
            last_grant_q <= SRC_B;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed and randomised checks of rr_mux_arb with a byte scoreboard.
module tb_rr_mux_arb;

    logic       clk;
    logic       reset_n;
    logic       a_valid_i;
    logic [7:0] a_data_i;
    logic       a_ready_o;
    logic       b_valid_i;
    logic [7:0] b_data_i;
    logic       b_ready_o;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic       out_src_o;
    logic       out_ready_i;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb_q[$];
    logic [8:0] exp_item;

    rr_mux_arb #(
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_valid_i   (a_valid_i),
        .a_data_i    (a_data_i),
        .a_ready_o   (a_ready_o),
        .b_valid_i   (b_valid_i),
        .b_data_i    (b_data_i),
        .b_ready_o   (b_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o),
        .out_ready_i (out_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [7:0] dat, input logic src);
        check({tag, "_vld"}, 32'(out_valid_o), 32'(vld));
        check({tag, "_dat"}, 32'(out_data_o), 32'(dat));
        check({tag, "_src"}, 32'(out_src_o), 32'(src));
    endtask

    task automatic check_rdy(input string tag, input logic ar, input logic br);
        check({tag, "_a_rdy"}, 32'(a_ready_o), 32'(ar));
        check({tag, "_b_rdy"}, 32'(b_ready_o), 32'(br));
    endtask

    initial begin
        reset_n     = 1'b0;
        a_valid_i   = 1'b1;
        a_data_i    = 8'hA0;
        b_valid_i   = 1'b1;
        b_data_i    = 8'hB0;
        out_ready_i = 1'b1;

        // Reset held two edges with both sources valid
        tick();
        tick();
        check_out("rst", 1'b0, 8'h00, 1'b0);
        check_rdy("rst", 1'b0, 1'b0);

        reset_n = 1'b1;
        settle();
        check_rdy("rst_rel", 1'b1, 1'b0);
        tick();
        check_out("rst_first", 1'b1, 8'hA0, 1'b0);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();
        check_out("rst_drain", 1'b0, 8'hA0, 1'b0);

        // Single source back-to-back
        a_valid_i = 1'b1;
        a_data_i  = 8'h11;
        settle();
        check_rdy("single", 1'b1, 1'b0);
        tick();
        check_out("single_11", 1'b1, 8'h11, 1'b0);
        a_data_i = 8'h22;
        tick();
        check_out("single_22", 1'b1, 8'h22, 1'b0);
        a_data_i = 8'h33;
        tick();
        check_out("single_33", 1'b1, 8'h33, 1'b0);
        a_valid_i = 1'b0;
        tick();
        check_out("single_drain", 1'b0, 8'h33, 1'b0);

        // Fresh reset, then contention alternates starting with A
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        a_valid_i = 1'b1;
        a_data_i  = 8'hAA;
        b_valid_i = 1'b1;
        b_data_i  = 8'hBB;
        tick();
        check_out("cont_0", 1'b1, 8'hAA, 1'b0);
        tick();
        check_out("cont_1", 1'b1, 8'hBB, 1'b1);
        tick();
        check_out("cont_2", 1'b1, 8'hAA, 1'b0);
        tick();
        check_out("cont_3", 1'b1, 8'hBB, 1'b1);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();
        check_out("cont_drain", 1'b0, 8'hBB, 1'b1);

        // Backpressure: B's byte held while A waits, then no-bubble reload
        b_valid_i = 1'b1;
        b_data_i  = 8'h5C;
        tick();
        check_out("bp_load", 1'b1, 8'h5C, 1'b1);
        b_valid_i   = 1'b0;
        out_ready_i = 1'b0;
        a_valid_i   = 1'b1;
        a_data_i    = 8'h7E;
        settle();
        check_rdy("bp_stall", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("bp_hold", 1'b1, 8'h5C, 1'b1);
            check_rdy("bp_hold", 1'b0, 1'b0);
        end
        out_ready_i = 1'b1;
        settle();
        check_rdy("bp_release", 1'b1, 1'b0);
        tick();
        check_out("bp_reload", 1'b1, 8'h7E, 1'b0);
        a_valid_i = 1'b0;
        tick();
        check_out("bp_drain", 1'b0, 8'h7E, 1'b0);

        // Idle drain: one-cycle valid, then B wins next contention
        a_valid_i = 1'b1;
        a_data_i  = 8'h42;
        tick();
        check_out("idle_load", 1'b1, 8'h42, 1'b0);
        a_valid_i = 1'b0;
        tick();
        check_out("idle_drain", 1'b0, 8'h42, 1'b0);
        tick();
        check_out("idle_stay", 1'b0, 8'h42, 1'b0);
        a_valid_i = 1'b1;
        a_data_i  = 8'h01;
        b_valid_i = 1'b1;
        b_data_i  = 8'h02;
        settle();
        check_rdy("idle_cont", 1'b0, 1'b1);
        tick();
        check_out("idle_cont", 1'b1, 8'h02, 1'b1);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();

        // Mid-operation reset while holding under backpressure
        a_valid_i = 1'b1;
        a_data_i  = 8'h99;
        tick();
        check_out("mrst_load", 1'b1, 8'h99, 1'b0);
        a_valid_i   = 1'b0;
        out_ready_i = 1'b0;
        tick();
        check_out("mrst_hold", 1'b1, 8'h99, 1'b0);
        reset_n = 1'b0;
        tick();
        check_out("mrst", 1'b0, 8'h00, 1'b0);
        reset_n   = 1'b1;
        a_valid_i = 1'b1;
        a_data_i  = 8'h0A;
        b_valid_i = 1'b1;
        b_data_i  = 8'h0B;
        settle();
        check_rdy("mrst_cont", 1'b1, 1'b0);
        out_ready_i = 1'b1;
        tick();
        check_out("mrst_cont", 1'b1, 8'h0A, 1'b0);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();
        check_out("mrst_drain", 1'b0, 8'h0A, 1'b0);

        // Random traffic against an in-order scoreboard
        sb_q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            a_valid_i   = ($urandom_range(0, 99) < 60);
            a_data_i    = 8'($urandom);
            b_valid_i   = ($urandom_range(0, 99) < 60);
            b_data_i    = 8'($urandom);
            out_ready_i = ($urandom_range(0, 99) < 75);
            settle();
            check("rand_one_hot_rdy", 32'(a_ready_o & b_ready_o), 32'd0);
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("rand_unexpected_out", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_item = sb_q.pop_front();
                    check("rand_out", 32'({out_src_o, out_data_o}), 32'(exp_item));
                end
            end
            if (a_ready_o) sb_q.push_back({1'b0, a_data_i});
            if (b_ready_o) sb_q.push_back({1'b1, b_data_i});
            tick();
        end
        a_valid_i   = 1'b0;
        b_valid_i   = 1'b0;
        out_ready_i = 1'b1;
        settle();
        if (out_valid_o) begin
            exp_item = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
            check("rand_final_out", 32'({out_src_o, out_data_o}), 32'(exp_item));
        end
        check("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();
        check("rand_end_idle", 32'(out_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Registered two-source front end for the 8-bit 2:1 byte mux.
- Accepts bytes from source A and source B over independent valid/ready interfaces.
- A round-robin arbiter generates the mux select each cycle; the selected byte is captured into a single-entry output register with a valid/ready interface.
- Sits directly upstream of any single-consumer byte sink; it owns and drives the mux select rather than leaving it to the sink.

Parameters:
- DATA_W, 8, width of each source byte and of the output data.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- a_valid_i  input  1  source A has a byte.
- a_data_i  input  DATA_W  source A byte.
- a_ready_o  output  1  source A byte is accepted this cycle.
- b_valid_i  input  1  source B has a byte.
- b_data_i  input  DATA_W  source B byte.
- b_ready_o  output  1  source B byte is accepted this cycle.
- out_valid_o  output  1  output register holds a byte.
- out_data_o  output  DATA_W  registered selected byte.
- out_src_o  output  1  source of the held byte: 0 = A, 1 = B.
- out_ready_i  input  1  sink accepts the held byte.

Behaviour:
- Reset (reset_n low at a clk edge) clears out_valid_o, out_data_o and out_src_o to 0, and sets last_grant to 1 (B), so A wins the first contention.
- Reset overrides everything in that cycle; any byte in flight is dropped.
- can_load = !out_valid_o | out_ready_i, so a full register that is being drained can reload in the same cycle.
- Grant rules, evaluated only when can_load is 1:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source that is not last_grant.
  - Neither valid: no grant.
- sel = 1 when B is granted, else 0. sel drives the Mux select; the Mux output is the register D input.
- a_ready_o = can_load & grant_A; b_ready_o = can_load & grant_B. These are combinational, and at most one is high per cycle.
- On a grant edge: out_data_o <= mux output, out_src_o <= sel, out_valid_o <= 1, last_grant <= sel.
- If no grant and out_ready_i & out_valid_o: out_valid_o <= 0; out_data_o and out_src_o hold their values.
- If no grant and out_valid_o & !out_ready_i: the register holds (backpressure). Both readys are 0 and sources must hold their data.
- last_grant updates only on an actual grant, never on idle cycles.
- Latency: a byte accepted at edge N is visible on out_data_o after edge N. Throughput is 1 byte/cycle with continuous out_ready_i.
- Fairness: with both sources continuously valid and the sink always ready, the output alternates A,B,A,B,... starting with A after reset.
- Output data and source are stable while out_valid_o & !out_ready_i.
- Valid inputs are not required to stay asserted; a source dropping valid before acceptance is legal.

Decomposition:
- Shared package rr_mux_pkg holds:
  - localparam DATA_W_DEFAULT = 8.
  - typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e, used for last_grant, sel and out_src_o.
- One sub-module: the existing Mux (a_i = a_data_i, b_i = b_data_i, sel_i = sel, y_o to register D).
- The arbiter and output register stay in rr_mux_arb.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with both sources valid -> out_valid_o = 0, out_data_o = 0x00, a_ready_o = b_ready_o = 0. After release, first accepted byte is from A.
- Single source: A sends 0x11, 0x22, 0x33 back-to-back, B idle, sink ready -> outputs 0x11, 0x22, 0x33 on consecutive cycles, out_src_o = 0, each one cycle after acceptance.
- Contention: A holds 0xAA and B holds 0xBB continuously, sink ready -> output sequence 0xAA, 0xBB, 0xAA, 0xBB, with out_src_o toggling 0,1,0,1.
- Backpressure: load 0x5C from B, then hold out_ready_i = 0 for 3 cycles with A valid = 0x7E -> out_data_o stays 0x5C and a_ready_o = 0. After out_ready_i rises, 0x7E loads on the same edge 0x5C drains (no bubble).
- Idle drain: single byte 0x42 from A, sink ready, no further valids -> out_valid_o high for exactly 1 cycle. last_grant stays A, so the next contention grants B.
- Mid-operation reset: with out_valid_o = 1 holding 0x99 and out_ready_i = 0, assert reset_n = 0 for one edge -> out_valid_o = 0, out_data_o = 0x00, and the next contention grants A.
- Random check: over 1000 random cycles, a scoreboard confirms every accepted byte appears once, in order, with the correct out_src_o, and at most one ready is high per cycle.
